// File: rtl/parm_skid_buf.sv
// parm_skid_buf: two-entry valid/ready skid buffer between pipeline stages; strict FIFO order.
// Latency: 1 cycle from accept to out_valid/out_data. Throughput: 1 word/cycle.
// Backpressure: in_ready is registered from next occupancy. The skid entry absorbs the word
// accepted in the cycle that out_ready drops.
// Ports: clk, rst (sync, active-high), flush (sync discard)
//        in_valid/in_ready/in_data   upstream handshake
//        out_valid/out_ready/out_data downstream handshake
//        count                        occupancy 0..2
module parm_skid_buf #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   count_q, count_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;

  logic accept;
  logic emit;

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

  always_comb begin
    count_d = count_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (count_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          count_d = ONE;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          skid_d  = in_data;
          count_d = FULL;
        end else if (emit && !accept) begin
          count_d = EMPTY;
        end else if (accept && emit) begin
          main_d = in_data;
        end
      end
      FULL: begin
        // in_ready is low here, so only the emit side can move.
        if (emit) begin
          main_d  = skid_q;
          count_d = ONE;
        end
      end
      default: count_d = count_q;
    endcase

    // Flush drops everything in flight. The data registers keep their old
    // contents, so a word accepted this cycle never reaches out_data.
    if (flush) begin
      count_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    out_valid_d = (count_d != EMPTY);
    in_ready_d  = (count_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

endmodule

// File: doc/parm_skid_buf.md
# parm_skid_buf

Parameterized N-bit, two-entry valid/ready skid buffer used as the registered boundary between pipeline stages of the pipelined CPU datapath. It is the receiving end of a stage's valid/ready handshake and the sending end toward the next stage. All outputs come from flops, so there is no combinational path from `out_ready` to `in_ready` and stages can be chained without long timing paths. A synchronous `flush` drops in-flight words on branch redirect.

## Interface
- `N`, default 5: data width in bits; legal for any N ≥ 1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of all buffered words.
- `in_valid`  in  1  upstream has a word on `in_data`.
- `in_ready`  out  1  buffer can accept a word this cycle (registered).
- `in_data`  in  N  upstream word.
- `out_valid`  out  1  `out_data` holds a valid word (registered).
- `out_ready`  in  1  downstream accepts the word this cycle.
- `out_data`  out  N  head word (registered).
- `count`  out  2  occupancy, 0..2.

## Operation
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- Storage consists of a main register (drives `out_data`) and a skid register. Order is strict FIFO.
- States are encoded by `count`. Transitions, evaluated at the clock edge when `rst` and `flush` are low:
  - EMPTY (0), accept: main ← `in_data`, go to ONE.
  - EMPTY (0), no accept: stay EMPTY.
  - ONE (1), accept and no emit: skid ← `in_data`, go to FULL.
  - ONE (1), emit and no accept: go to EMPTY.
  - ONE (1), accept and emit: main ← `in_data`, stay ONE.
  - ONE (1), neither: hold.
  - FULL (2): `in_ready` is 0, so no accept occurs. On emit, main ← skid and go to ONE. Otherwise hold.
- `out_valid` = (`count` ≠ 0), registered.
- `in_ready` = (next `count` < 2), registered.
- `out_data` stays stable while `out_valid && !out_ready`.
- When EMPTY, `out_data` keeps its last value. Downstream must ignore it.
- Flush:
  - Next state is EMPTY: `count`=0, `out_valid`=0, `in_ready`=1.
  - A word accepted in the flush cycle is discarded. Upstream treats it as consumed.
  - A word emitted in the flush cycle counts as delivered.
  - Data registers are not cleared.
- Reset has priority over flush, and flush has priority over transfers. While `rst` is high, all inputs are ignored.
- Reset values: `count`=0, `out_valid`=0, `in_ready`=1, `out_data`=0, skid=0.

## Timing
- Latency: a word accepted at edge k appears on `out_data` with `out_valid`=1 after edge k. The minimum is 1 cycle.
- Throughput: 1 word/cycle sustained while `out_ready` is held high. `in_ready` never drops in that case.
- Back-pressure:
  - `out_ready` low from ONE with one more accept: FULL after that edge, and `in_ready`=0 from the next cycle.
  - No word is lost: the skid register absorbs the word accepted in the cycle `in_ready` was still 1.
- Release from FULL: after an emit edge, `in_ready`=1 and `out_data`=old skid word.
- Reset mid-operation: buffered words are lost. One cycle after `rst` falls, the first word can be accepted.

## Test plan
- Reset then idle, N=5: `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=5'b00000 throughout.
- Streaming: `out_ready`=1; feed 1,2,3,4 on consecutive cycles. Required response: `out_data` 1,2,3,4 on the 4 cycles after each accept, `count` stays 1, `in_ready` stays 1.
- Stall: `out_ready`=0; feed 7 then 9. Required response: `count`=2, `in_ready`=0, and `out_data`=7 stable. Then raise `out_ready`: 7 is emitted, `out_data`=9 next cycle, `in_ready`=1, and 9 is emitted after that.
- Simultaneous accept and emit in ONE with `out_data`=3, accepting 5: `count` stays 1 and `out_data`=5.
- Flush while FULL (words 10, 11), with `in_valid`=1 and data 12 in the same cycle: next cycle `count`=0, `out_valid`=0, `in_ready`=1, and 12 never appears at the output.
- `rst` asserted while FULL: next cycle all outputs are at reset values. Then a word 6 is accepted and appears on `out_data` one cycle later.
